// File: rtl/dac_controller.sv
// dac_controller
//   Serial write controller for an 8-channel, 16-bit DAC (DAC8568-style
//   32-bit frames, MSB first). Each channel keeps only the most recent word
//   from the PID core together with a pending flag. Pending channels are served
//   round-robin. After reset a single internal-reference-enable frame is sent
//   before any data frame.
//
// Ports
//   clk_in         serial/system clock
//   reset_in       asynchronous active-high reset
//   data_in        unsigned DAC code
//   chan_in        target channel of data_in
//   data_valid_in  latch data_in into buffer[chan_in] and mark it pending
//   n_sync_out     frame sync to the DAC, active low
//   sclk_out       serial clock to the DAC (n_sync_out | clk_in)
//   din_out        serial data to the DAC, changes on rising clk_in
//   busy_out       high whenever the controller is not idle
//   wr_done_out    one-cycle pulse after a data frame completes
//   chan_done_out  channel of the last completed data frame
module dac_controller #(
  parameter int N_CHAN = 8,
  parameter int W_DATA = 16,
  parameter int T_GAP  = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic [2:0]        chan_in,
  input  logic              data_valid_in,
  output logic              n_sync_out,
  output logic              sclk_out,
  output logic              din_out,
  output logic              busy_out,
  output logic              wr_done_out,
  output logic [2:0]        chan_done_out
);

  localparam logic [31:0]   INIT_FRAME = 32'h0800_0001;
  localparam logic [3:0]    N_CHAN_L   = 4'(N_CHAN);
  localparam int            GW         = (T_GAP > 1) ? $clog2(T_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'(T_GAP - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t            state;
  logic [W_DATA-1:0] buffer [N_CHAN];
  logic [N_CHAN-1:0] pending;
  logic [2:0]        last_chan;
  logic [2:0]        cur_chan;
  logic              is_data;
  logic [31:0]       shreg;
  logic [4:0]        bit_cnt;
  logic [GW-1:0]     gap_cnt;

  logic [2:0]        sel_chan;
  logic              sel_found;
  logic [3:0]        search_idx;
  logic [31:0]       data_frame;
  logic              wr_ok;

  // The shift register is zero-filled as it shifts, so it is all zeros
  // outside a frame and din_out idles low without extra gating.
  assign din_out  = shreg[31];
  assign sclk_out = n_sync_out | clk_in;
  assign busy_out = (state != ST_IDLE);

  assign wr_ok = data_valid_in && ({1'b0, chan_in} < N_CHAN_L);

  // Round-robin pick: first pending channel starting just after last_chan.
  always_comb begin
    sel_chan   = last_chan;
    sel_found  = 1'b0;
    search_idx = '0;
    for (int i = 1; i <= N_CHAN; i++) begin
      search_idx = {1'b0, last_chan} + 4'(i);
      if (search_idx >= N_CHAN_L) begin
        search_idx = search_idx - N_CHAN_L;
      end
      if (!sel_found && pending[search_idx[2:0]]) begin
        sel_chan  = search_idx[2:0];
        sel_found = 1'b1;
      end
    end
  end

  // Write-and-update frame: prefix 0, control 3, address, data, feature 0.
  assign data_frame = {4'b0000, 4'b0011, 1'b0, sel_chan, buffer[sel_chan], 4'b0000};

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state         <= ST_INIT;
      n_sync_out    <= 1'b1;
      shreg         <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      wr_done_out   <= 1'b0;
      chan_done_out <= '0;
      pending       <= '0;
      last_chan     <= 3'(N_CHAN - 1);
      cur_chan      <= '0;
      is_data       <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      wr_done_out <= 1'b0;

      case (state)
        ST_INIT: begin
          shreg      <= INIT_FRAME;
          bit_cnt    <= '0;
          is_data    <= 1'b0;
          n_sync_out <= 1'b0;
          state      <= ST_SHIFT;
        end

        ST_IDLE: begin
          if (|pending) begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          shreg             <= data_frame;
          pending[sel_chan] <= 1'b0;
          last_chan         <= sel_chan;
          cur_chan          <= sel_chan;
          is_data           <= 1'b1;
          bit_cnt           <= '0;
          n_sync_out        <= 1'b0;
          state             <= ST_SHIFT;
        end

        ST_SHIFT: begin
          shreg   <= {shreg[30:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            n_sync_out <= 1'b1;
            gap_cnt    <= '0;
            state      <= ST_GAP;
            if (is_data) begin
              wr_done_out   <= 1'b1;
              chan_done_out <= cur_chan;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= ST_INIT;
      endcase

      // Placed after the case so a write landing on the same channel in
      // ST_LOAD re-arms its pending bit; the frame already took the old value.
      if (wr_ok) begin
        buffer[chan_in]  <= data_in;
        pending[chan_in] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_controller.sv
// tb_dac_controller
//   Directed and randomized checks of dac_controller. A monitor reassembles
//   every frame from din_out on falling sclk_out and compares it with a
//   channel-level model (latest value and pending flag per channel,
//   round-robin choice from the last served channel).
module tb_dac_controller;

  localparam int N_CHAN = 8;
  localparam int T_GAP  = 2;
  localparam logic [31:0] INIT_FRAME = 32'h0800_0001;

  logic        clk_in;
  logic        reset_in;
  logic [15:0] data_in;
  logic [2:0]  chan_in;
  logic        data_valid_in;
  logic        n_sync_out;
  logic        sclk_out;
  logic        din_out;
  logic        busy_out;
  logic        wr_done_out;
  logic [2:0]  chan_done_out;

  dac_controller #(.N_CHAN(N_CHAN), .W_DATA(16), .T_GAP(T_GAP)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .data_in       (data_in),
    .chan_in       (chan_in),
    .data_valid_in (data_valid_in),
    .n_sync_out    (n_sync_out),
    .sclk_out      (sclk_out),
    .din_out       (din_out),
    .busy_out      (busy_out),
    .wr_done_out   (wr_done_out),
    .chan_done_out (chan_done_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + monitor ----------------
  logic        edge_v;
  logic [2:0]  edge_ch;
  logic [15:0] edge_d;

  always @(posedge clk_in) begin
    edge_v  <= data_valid_in && !reset_in;
    edge_ch <= chan_in;
    edge_d  <= data_in;
  end

  logic [15:0] m_buf [8];
  logic [7:0]  m_pend = '0;
  int          m_last = N_CHAN - 1;
  bit          m_init_exp = 1'b1;
  bit          in_frame = 1'b0;
  bit          after_frame = 1'b0;
  bit          prev_nsync = 1'b1;
  int          cap_n = 0;
  int          gap_len = 0;
  logic [31:0] cap;
  logic [31:0] exp_frame;
  bit          exp_data;
  logic [2:0]  exp_chan;
  logic [31:0] frames_seen [$];
  int          wr_pulses = 0;
  logic [2:0]  last_done_chan = '0;

  always @(negedge clk_in) begin
    bit exp_wr;
    int c;
    #1;
    if (reset_in) begin
      for (int i = 0; i < 8; i++) m_buf[i] = '0;
      m_pend      = '0;
      m_last      = N_CHAN - 1;
      m_init_exp  = 1'b1;
      in_frame    = 1'b0;
      after_frame = 1'b0;
      prev_nsync  = 1'b1;
      check("rst_nsync", 32'(n_sync_out), 32'd1);
      check("rst_wr_done", 32'(wr_done_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd1);
    end else begin
      exp_wr = 1'b0;
      if (in_frame && n_sync_out) begin
        check("frame_len", 32'(cap_n), 32'd32);
        check("frame_bits", cap, exp_frame);
        $display("[TB] frame %08h expected %08h", cap, exp_frame);
        frames_seen.push_back(cap);
        exp_wr      = exp_data;
        in_frame    = 1'b0;
        gap_len     = 0;
        after_frame = 1'b1;
      end
      check("wr_done", 32'(wr_done_out), 32'(exp_wr));
      if (wr_done_out) begin
        wr_pulses++;
        last_done_chan = chan_done_out;
      end
      if (exp_wr) check("chan_done", 32'(chan_done_out), 32'(exp_chan));

      if (prev_nsync && !n_sync_out) begin
        if (after_frame) check("gap_len_ok", 32'(gap_len >= T_GAP + 2), 32'd1);
        if (m_init_exp) begin
          exp_frame  = INIT_FRAME;
          exp_data   = 1'b0;
          m_init_exp = 1'b0;
        end else begin
          c = -1;
          for (int i = 1; i <= N_CHAN; i++) begin
            if (c < 0 && m_pend[(m_last + i) % N_CHAN]) c = (m_last + i) % N_CHAN;
          end
          check("frame_has_pending", 32'(c >= 0), 32'd1);
          if (c >= 0) begin
            exp_chan  = 3'(c);
            exp_frame = {8'h03, 1'b0, 3'(c), m_buf[c], 4'h0};
            exp_data  = 1'b1;
            m_pend[c] = 1'b0;
            m_last    = c;
          end else begin
            exp_frame = '0;
            exp_data  = 1'b0;
          end
        end
        in_frame = 1'b1;
        cap_n    = 0;
        cap      = '0;
      end

      if (!n_sync_out) begin
        if (in_frame) begin
          cap = {cap[30:0], din_out};
          cap_n++;
        end
        check("sclk_active", 32'(sclk_out), 32'd0);
      end else begin
        gap_len++;
        check("idle_lines", {30'd0, sclk_out, din_out}, 32'd2);
      end

      if (edge_v && edge_ch < N_CHAN) begin
        m_buf[edge_ch]  = edge_d;
        m_pend[edge_ch] = 1'b1;
      end
      prev_nsync = n_sync_out;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cycle();
    @(negedge clk_in);
    #2;
  endtask

  task automatic write(input logic [2:0] ch, input logic [15:0] d);
    chan_in       = ch;
    data_in       = d;
    data_valid_in = 1'b1;
    cycle();
    data_valid_in = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_seen.size() < n && k < 500) begin
      cycle();
      k++;
    end
    check("wait_frames", 32'(frames_seen.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_out && k < 500) begin
      cycle();
      k++;
    end
    check("wait_idle", 32'(busy_out), 32'd0);
  endtask

  task automatic wait_low();
    int k = 0;
    while (n_sync_out && k < 100) begin
      cycle();
      k++;
    end
    check("wait_low", 32'(n_sync_out), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] d;
    logic [31:0] f;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pulses0;
    int cnt;

    vecs[0] = '{3'd0, 16'hFFFF, 32'h030FFFF0};
    vecs[1] = '{3'd7, 16'h0000, 32'h03700000};
    vecs[2] = '{3'd4, 16'h8001, 32'h03480010};
    vecs[3] = '{3'd2, 16'h1234, 32'h03212340};
    vecs[4] = '{3'd6, 16'h00FF, 32'h03600FF0};
    vecs[5] = '{3'd3, 16'hFEDC, 32'h033FEDC0};

    reset_in      = 1'b0;
    data_valid_in = 1'b0;
    chan_in       = '0;
    data_in       = '0;
    #1 reset_in = 1'b1;
    repeat (3) cycle();
    check("reset_n_sync", 32'(n_sync_out), 32'd1);
    check("reset_din", 32'(din_out), 32'd0);
    check("reset_wr_done", 32'(wr_done_out), 32'd0);
    check("reset_chan_done", 32'(chan_done_out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd1);
    reset_in = 1'b0;

    // Init frame, then busy drops after T_GAP gap cycles.
    wait_frames(1);
    check("init_frame", frames_seen[0], INIT_FRAME);
    check("init_no_pulse", 32'(wr_pulses), 32'd0);
    cnt = 0;
    while (busy_out && cnt < 50) begin
      cycle();
      cnt++;
    end
    check("init_busy_gap", 32'(cnt), 32'(T_GAP));

    // Single write with latency check.
    write(3'd3, 16'hABCD);
    check("lat_e0", 32'(n_sync_out), 32'd1);
    cycle();
    check("lat_e1", 32'(n_sync_out), 32'd1);
    cycle();
    check("lat_e2", 32'(n_sync_out), 32'd0);
    wait_frames(2);
    check("ch3_frame", frames_seen[1], 32'h033ABCD0);
    check("ch3_pulses", 32'(wr_pulses), 32'd1);
    check("ch3_chan_done", 32'(last_done_chan), 32'd3);
    wait_idle();

    // Overwrite of ch5 during another frame: only latest value goes out.
    write(3'd6, 16'h0606);
    wait_low();
    write(3'd5, 16'h1111);
    write(3'd5, 16'h2222);
    wait_frames(4);
    wait_idle();
    repeat (40) cycle();
    check("ch5_single", 32'(frames_seen.size()), 32'd4);
    check("ch6_frame", frames_seen[2], 32'h03606060);
    check("ch5_frame", frames_seen[3], 32'h03522220);

    // Burst: order 7, 0, 2.
    base    = frames_seen.size();
    pulses0 = wr_pulses;
    write(3'd7, 16'h7777);
    write(3'd0, 16'h0A0A);
    write(3'd2, 16'h2B2B);
    wait_frames(base + 3);
    check("rr_first", frames_seen[base], 32'h03777770);
    check("rr_second", frames_seen[base + 1], 32'h0300A0A0);
    check("rr_third", frames_seen[base + 2], 32'h0322B2B0);
    wait_idle();
    check("rr_pulses", 32'(wr_pulses - pulses0), 32'd3);

    // Write to ch1 landing in the ST_LOAD cycle of ch1.
    base = frames_seen.size();
    write(3'd1, 16'h0001);
    cycle();
    write(3'd1, 16'h0002);
    check("collide_in_load", 32'(n_sync_out), 32'd0);
    wait_frames(base + 2);
    check("collide_old", frames_seen[base], 32'h03100010);
    check("collide_new", frames_seen[base + 1], 32'h03100020);
    wait_idle();

    // Reset mid-frame with ch6 pending.
    write(3'd4, 16'h4444);
    wait_low();
    repeat (9) cycle();
    write(3'd6, 16'h6666);
    base = frames_seen.size();
    reset_in = 1'b1;
    #1;
    check("async_reset_nsync", 32'(n_sync_out), 32'd1);
    cycle();
    cycle();
    reset_in = 1'b0;
    wait_frames(base + 1);
    check("post_reset_init", frames_seen[base], INIT_FRAME);
    repeat (60) cycle();
    check("ch6_dropped", 32'(frames_seen.size()), 32'(base + 1));
    check("post_reset_idle", 32'(busy_out), 32'd0);

    // Table-driven single writes.
    for (int i = 0; i < 6; i++) begin
      base = frames_seen.size();
      write(vecs[i].ch, vecs[i].d);
      wait_frames(base + 1);
      check($sformatf("vec%0d", i), frames_seen[base], vecs[i].f);
      wait_idle();
    end

    // Randomized traffic checked by the monitor model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        chan_in       = 3'($urandom_range(0, 7));
        data_in       = 16'($urandom);
        data_valid_in = 1'b1;
      end else begin
        data_valid_in = 1'b0;
      end
      cycle();
    end
    data_valid_in = 1'b0;
    cnt = 0;
    while ((busy_out || m_pend != 0) && cnt < 3000) begin
      cycle();
      cnt++;
    end
    check("drain_pending", 32'(m_pend), 32'd0);
    check("drain_idle", 32'(busy_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
